// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer width derivation and
// a default data-word type.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [DEF_WIDTH-1:0] word_t;

  // The pointer carries one extra wrap bit above the address bits so that
  // the full and empty states can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for sync_fifo. It has a synchronous write and a
// registered read, and it owns the pop_data output register.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-2:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [ptr_w(DEPTH)-2:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_p1;

  // Storage array: reset does not clear it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register: loads only when a pop is accepted, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)        rd_data_p1 <= '0;
    else if (rd_en) rd_data_p1 <= mem[rd_addr];
  end

  assign rd_data = rd_data_p1;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and combinational full/empty flags.
// The optional occupancy output `level` is enabled by defining FIFO_LEVEL_EN.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_en,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_en,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_p0;
  logic [PTR_W-1:0] rd_ptr_p0;
  logic             push_acc;
  logic             pop_acc;

  assign empty = (wr_ptr_p0 == rd_ptr_p0);
  assign full  = (wr_ptr_p0[PTR_W-2:0] == rd_ptr_p0[PTR_W-2:0]) &&
                 (wr_ptr_p0[PTR_W-1] != rd_ptr_p0[PTR_W-1]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign pop_acc  = pop_en & ~empty;
  assign push_acc = push_en & (~full | pop_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
    end else begin
      if (push_acc) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (pop_acc)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
    end
  end

  // Stage boundary: storage write and registered read data (1-cycle latency).
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_p0[PTR_W-2:0]),
    .wr_data (push_data),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_p0[PTR_W-2:0]),
    .rd_data (pop_data)
  );

`ifdef FIFO_LEVEL_EN
  assign level = wr_ptr_p0 - rd_ptr_p0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random bench for sync_fifo with a queue-based reference model.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push_en = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             pop_en = 1'b0;
  logic [WIDTH-1:0] pop_data;
  logic             full;
  logic             empty;
`ifdef FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_pd = '0;

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_en   (push_en),
    .push_data (push_data),
    .pop_en    (pop_en),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pop_data"}, 32'(pop_data), 32'(exp_pd));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
`ifdef FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(level), 32'(model_q.size()));
`endif
  endtask

  // One clock with the given inputs; the model decides acceptance from its
  // own occupancy before the edge, then the outputs are checked after it.
  task automatic step(input string tag, input logic p, input logic [WIDTH-1:0] d,
                      input logic q);
    logic pa, wa;
    push_en   = p;
    push_data = d;
    pop_en    = q;
    pa = q && (model_q.size() > 0);
    wa = p && ((model_q.size() < DEPTH) || pa);
    @(posedge clk);
    #1;
    if (pa) exp_pd = model_q.pop_front();
    if (wa) model_q.push_back(d);
    push_en = 1'b0;
    pop_en  = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b1;
    push_en = 1'b1;
    pop_en  = 1'b1;
    push_data = 8'hEE;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    push_en = 1'b0;
    pop_en  = 1'b0;
    model_q.delete();
    exp_pd = '0;
    check_all(tag);
  endtask

  initial begin
    // Reset, with push and pop also asserted to show reset priority.
    do_reset("reset");

    // Overfill: values 5, 6, 7 must be dropped.
    for (int i = 1; i <= 7; i++) step("overfill", 1'b1, 8'(i), 1'b0);
    check("overfill.full_const", 32'(full), 32'd1);

    // Drain: 1, 2, 3, 4 then pop_data holds 4.
    for (int i = 0; i < 6; i++) step("drain", 1'b0, '0, 1'b1);
    check("drain.hold_const", 32'(pop_data), 32'd4);

    // Wrap-around.
    for (int i = 0; i < 3; i++) step("wrap_push", 1'b1, 8'(20 + i), 1'b0);
    for (int i = 0; i < 3; i++) step("wrap_pop", 1'b0, '0, 1'b1);
    for (int i = 10; i <= 13; i++) step("wrap_push2", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step("wrap_pop2", 1'b0, '0, 1'b1);
    check("wrap.last_const", 32'(pop_data), 32'd13);

    // Simultaneous push and pop at full.
    for (int i = 1; i <= 4; i++) step("sim_fill", 1'b1, 8'(i), 1'b0);
    step("sim_full", 1'b1, 8'd9, 1'b1);
    check("sim_full.pd_const", 32'(pop_data), 32'd1);
    for (int i = 0; i < 5; i++) step("sim_drain", 1'b0, '0, 1'b1);

    // Simultaneous push and pop when empty: no fall-through.
    step("sim_empty", 1'b1, 8'h55, 1'b1);
    step("sim_empty_pop", 1'b0, '0, 1'b1);

    // Simultaneous push and pop when partially filled.
    step("mid_fill", 1'b1, 8'h61, 1'b0);
    step("mid_both", 1'b1, 8'h62, 1'b1);
    step("mid_pop", 1'b0, '0, 1'b1);

    // Reset mid-operation discards stored data.
    step("rst_fill", 1'b1, 8'h07, 1'b0);
    step("rst_fill", 1'b1, 8'h08, 1'b0);
    do_reset("rst_mid");
    step("rst_pop_ignored", 1'b0, '0, 1'b1);
    check("rst_mid.pd_const", 32'(pop_data), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++)
      step("random", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
